// File: rtl/pipe_stage_regs_if.sv
// Bundle between the pipeline register block and its surroundings:
// fetch/hazard/datapath inputs, stage registers and status outputs.
interface pipe_stage_regs_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_in;
  logic             stall;
  logic             flush;
  logic [31:0]      alu_result;
  logic [31:0]      store_data;
  logic [31:0]      mem_rdata;
  logic [31:0]      instrIFID;
  logic [31:0]      instrIDEX;
  logic [31:0]      instrEXMEM;
  logic [31:0]      instrMEMWB;
  logic [31:0]      aluEXMEM_Data;
  logic [31:0]      aluMEMWB_Data;
  logic [31:0]      EXMEM_Data2Mem;
  logic [31:0]      MEMWB_MemData;
  logic [3:0]       stage_valid;
  logic             pc_en;
  logic             retire;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instr_in, stall, flush,
    output alu_result, store_data, mem_rdata,
    input  instrIFID, instrIDEX, instrEXMEM, instrMEMWB,
    input  aluEXMEM_Data, aluMEMWB_Data,
    input  EXMEM_Data2Mem, MEMWB_MemData,
    input  stage_valid, pc_en, retire,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_in, stall, flush,
    input  alu_result, store_data, mem_rdata,
    output instrIFID, instrIDEX, instrEXMEM, instrMEMWB,
    output aluEXMEM_Data, aluMEMWB_Data,
    output EXMEM_Data2Mem, MEMWB_MemData,
    output stage_valid, pc_en, retire,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// Five-stage pipeline registers: IF/ID..MEM/WB instruction and data
// latches with stall bubbles, flush kill and saturating event counters.
module pipe_stage_regs #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input logic            clk,
  input logic            rst_n,
  pipe_stage_regs_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, instr: NOP_INSTR};

  stage_t           ifid, idex, exmem, memwb;
  logic [31:0]      alu_exmem, alu_memwb;
  logic [31:0]      st_exmem, mem_memwb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             do_flush;

  // stall wins: a flush during a stall is dropped entirely
  assign do_flush = bus.flush & ~bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid  <= BUBBLE;
      idex  <= BUBBLE;
      exmem <= BUBBLE;
      memwb <= BUBBLE;
    end else begin
      unique case (1'b1)
        bus.stall: begin
          idex <= BUBBLE;
        end
        do_flush: begin
          ifid <= BUBBLE;
          idex <= ifid;
        end
        default: begin
          ifid <= '{valid: 1'b1, instr: bus.instr_in};
          idex <= ifid;
        end
      endcase
      exmem <= idex;
      memwb <= exmem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_exmem <= '0;
      alu_memwb <= '0;
      st_exmem  <= '0;
      mem_memwb <= '0;
    end else begin
      alu_exmem <= bus.alu_result;
      alu_memwb <= alu_exmem;
      st_exmem  <= bus.store_data;
      mem_memwb <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (do_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.pc_en          = ~bus.stall;
  assign bus.instrIFID      = ifid.instr;
  assign bus.instrIDEX      = idex.instr;
  assign bus.instrEXMEM     = exmem.instr;
  assign bus.instrMEMWB     = memwb.instr;
  assign bus.stage_valid    = {ifid.valid, idex.valid,
                               exmem.valid, memwb.valid};
  assign bus.retire         = memwb.valid;
  assign bus.aluEXMEM_Data  = alu_exmem;
  assign bus.aluMEMWB_Data  = alu_memwb;
  assign bus.EXMEM_Data2Mem = st_exmem;
  assign bus.MEMWB_MemData  = mem_memwb;
  assign bus.stall_cnt      = stall_cnt;
  assign bus.flush_cnt      = flush_cnt;

endmodule

// File: doc/pipe_stage_regs.md
PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction word injected as a bubble (SLL $0,$0,0).
REQ-002 SHALL have parameter CNT_W, default 16, the width of the stall and flush counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port instr_in  input  32  fetched instruction from instruction memory.
REQ-006 SHALL have port stall  input  1  load-use/jump hazard stall from the forwarding unit.
REQ-007 SHALL have port flush  input  1  taken jump/branch resolved in the IF/ID stage; kills the fetched word.
REQ-008 SHALL have port alu_result  input  32  EX-stage ALU output.
REQ-009 SHALL have port store_data  input  32  EX-stage (already forwarded) rt value for SW.
REQ-010 SHALL have port mem_rdata  input  32  data-memory read data for the instruction in EX/MEM.
REQ-011 SHALL have ports instrIFID, instrIDEX, instrEXMEM, instrMEMWB  output  32 each  stage instruction registers.
REQ-012 SHALL have ports aluEXMEM_Data, aluMEMWB_Data, EXMEM_Data2Mem, MEMWB_MemData  output  32 each  stage data registers.
REQ-013 SHALL have port stage_valid  output  4  valid bits {IFID,IDEX,EXMEM,MEMWB}, bit 3 = IFID.
REQ-014 SHALL have port pc_en  output  1  PC/fetch advance enable.
REQ-015 SHALL have port retire  output  1  high for one cycle while a valid instruction is in MEM/WB.
REQ-016 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-017 SHALL drive pc_en = ~stall combinationally; pc_en has no other dependency.
REQ-018 SHALL, on each edge with stall=0 and flush=0, perform: instrIFID<=instr_in (valid 1); instrIDEX<=instrIFID; instrEXMEM<=instrIDEX; instrMEMWB<=instrEXMEM; valid bits shift with their instructions.
REQ-019 SHALL, on an edge with stall=0 and flush=1, load instrIFID<=NOP_INSTR with valid 0; the other stages advance as in REQ-018.
REQ-020 SHALL, on an edge with stall=1, hold instrIFID and its valid bit, load instrIDEX<=NOP_INSTR with valid 0, and advance EX/MEM and MEM/WB normally.
REQ-021 SHALL give stall priority over flush: with both high, flush is ignored and flush_cnt does not increment.
REQ-022 SHALL update data registers every edge regardless of stall/flush: aluEXMEM_Data<=alu_result; EXMEM_Data2Mem<=store_data; aluMEMWB_Data<=aluEXMEM_Data; MEMWB_MemData<=mem_rdata.
REQ-023 SHALL give one-cycle latency per stage: a word accepted at edge N appears on instrMEMWB after edge N+3 with no stalls, N+3+k with k stall cycles while in IF/ID.
REQ-024 SHALL drive retire = stage_valid[0] (registered, no combinational path from inputs).
REQ-025 SHALL increment stall_cnt on each edge with stall=1, and flush_cnt on each edge with flush=1 and stall=0; both saturate at all-ones and never wrap.
REQ-026 SHALL treat a bubble identically to any other instruction downstream (no special-casing beyond valid=0).

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously, including mid-stall or mid-flush), set all four instr registers to NOP_INSTR, all data registers to 0, stage_valid to 4'b0000, stall_cnt and flush_cnt to 0; retire is therefore 0.
REQ-028 SHALL resume with REQ-018 behaviour on the first rising edge after rst_n deasserts; no instruction held before reset survives.

Verification
REQ-029 SHALL pass: reset, then instr_in = 32'h2001_0005, 32'h2002_0007, 32'h0022_1820 on three edges, no stall -> instrMEMWB = 32'h2001_0005 after edge 4, retire high that cycle, stage_valid = 4'b1111 after edge 4.
REQ-030 SHALL pass: LW 32'h8C01_0000 then ADD 32'h0021_1020; stall=1 one cycle while ADD in IF/ID -> instrIFID holds 32'h0021_1020, instrIDEX = NOP, stage_valid[2]=0, stall_cnt = 1, pc_en = 0 during the stall.
REQ-031 SHALL pass: flush=1 with instr_in = 32'hDEAD_BEEF -> instrIFID = NOP_INSTR, stage_valid[3]=0, flush_cnt increments by 1; retire stays 0 when that bubble reaches MEM/WB.
REQ-032 SHALL pass: stall=1 and flush=1 together -> IF/ID held, ID/EX bubble, stall_cnt +1, flush_cnt unchanged.
REQ-033 SHALL pass: stall held 2^CNT_W+3 cycles -> stall_cnt saturates at all-ones, no wrap.
REQ-034 SHALL pass: rst_n pulsed low between clock edges during a stall -> outputs reach reset values immediately, before the next edge.
